// File: rtl/uart_sender_arbiter.sv
// ---------------------------------------------------------------------------
// uart_sender_arbiter
//
// Shares one UART sender between several element sources (matrix-gen echo,
// matrix display, result printer).  A source raises src_req for the length
// of a whole transaction (one matrix or one summary).  The arbiter grants
// ownership round-robin, then moves the owner's elements one at a time to
// the sender: latch + ack, start pulse, wait for snd_done, repeat.  The
// owner keeps the sender until it drops src_req, so frames from different
// sources never interleave.
//
// Optional feature (compile-time macro SENDER_TIMEOUT_EN):
//   defined   - a 16-bit watchdog bounds each WAIT_DONE phase to TIMEOUT_CYC
//               cycles; on expiry timeout_err is set (sticky until rst) and
//               the owner continues with its next element.
//   undefined - WAIT_DONE waits for snd_done indefinitely; timeout_err is 0.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   src_req      [N_REQ]         per-source transaction request (level)
//   src_valid    [N_REQ]         per-source element valid, held until acked
//   src_data     [N_REQ*DATA_W]  packed element data, source i at i*DATA_W
//   src_flags    [N_REQ*FLAG_W]  packed flags {sum_elem,sum_head,id,
//                                newline,last_col}, source i at i*FLAG_W
//   src_ack      [N_REQ]         one-cycle pulse: owner's element accepted
//   src_grant    [N_REQ]         one-hot current owner, zero when idle
//   snd_start                    one-cycle start pulse to the sender
//   snd_data     [DATA_W]        registered element for the sender
//   snd_flags    [FLAG_W]        registered flags for the sender
//   snd_done                     sender finished current element (pulse)
//   arb_busy                     high whenever the arbiter is not idle
//   timeout_err                  sticky watchdog error (optional feature)
// ---------------------------------------------------------------------------
module uart_sender_arbiter #(
  parameter int N_REQ       = 3,
  parameter int DATA_W      = 8,
  parameter int FLAG_W      = 5,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          src_req,
  input  logic [N_REQ-1:0]          src_valid,
  input  logic [N_REQ*DATA_W-1:0]   src_data,
  input  logic [N_REQ*FLAG_W-1:0]   src_flags,
  output logic [N_REQ-1:0]          src_ack,
  output logic [N_REQ-1:0]          src_grant,
  output logic                      snd_start,
  output logic [DATA_W-1:0]         snd_data,
  output logic [FLAG_W-1:0]         snd_flags,
  input  logic                      snd_done,
  output logic                      arb_busy,
  output logic                      timeout_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN   = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;

  // Round-robin pick: first requester strictly after rr_ptr, wrapping.
  logic             win_any;
  logic [N_REQ-1:0] win_hot;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    win_any = 1'b0;
    win_hot = '0;
    win_idx = rr_ptr;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!win_any && src_req[cand]) begin
        win_any       = 1'b1;
        win_hot[cand] = 1'b1;
        win_idx       = cand;
      end
    end
  end

  // Owner view: the grant vector is one-hot, so AND-OR muxing is enough
  // and non-owner valids/data never reach the datapath.
  logic              own_req;
  logic              own_vld;
  logic [DATA_W-1:0] own_data;
  logic [FLAG_W-1:0] own_flags;

  always_comb begin
    own_req   = |(src_req & src_grant);
    own_vld   = |(src_valid & src_grant);
    own_data  = '0;
    own_flags = '0;
    for (int i = 0; i < N_REQ; i++) begin
      own_data  = own_data  | (src_data[i*DATA_W +: DATA_W] & {DATA_W{src_grant[i]}});
      own_flags = own_flags | (src_flags[i*FLAG_W +: FLAG_W] & {FLAG_W{src_grant[i]}});
    end
  end

`ifdef SENDER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wd_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= IDX_W'(N_REQ - 1);
      src_ack     <= '0;
      src_grant   <= '0;
      snd_start   <= 1'b0;
      snd_data    <= '0;
      snd_flags   <= '0;
      arb_busy    <= 1'b0;
      timeout_err <= 1'b0;
`ifdef SENDER_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      src_ack   <= '0;
      snd_start <= 1'b0;
      case (state)
        // Idle -> ownership: grant becomes visible with the state change.
        S_IDLE: begin
          if (win_any) begin
            src_grant <= win_hot;
            rr_ptr    <= win_idx;
            state     <= S_OWN;
            arb_busy  <= 1'b1;
          end
        end
        // Ownership: release on dropped request, otherwise take one element.
        S_OWN: begin
          if (!own_req) begin
            src_grant <= '0;
            state     <= S_IDLE;
            arb_busy  <= 1'b0;
          end else if (own_vld) begin
            snd_data  <= own_data;
            snd_flags <= own_flags;
            src_ack   <= src_grant;
            state     <= S_ISSUE;
          end
        end
        // Issue: start pulse lands while waiting for completion.
        S_ISSUE: begin
          snd_start <= 1'b1;
          state     <= S_WAIT;
`ifdef SENDER_TIMEOUT_EN
          wd_cnt    <= '0;
`endif
        end
        // Wait for the sender; snd_data/snd_flags stay put meanwhile.
        S_WAIT: begin
          if (snd_done) begin
            state <= S_OWN;
`ifdef SENDER_TIMEOUT_EN
          end else if (wd_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_OWN;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
`endif
          end
        end
        default: begin
          state     <= S_IDLE;
          src_grant <= '0;
          arb_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sender_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_sender_arbiter: directed self-checking bench for uart_sender_arbiter
// (3 requesters, 8-bit data, 5-bit flags, watchdog limit 20 cycles).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_sender_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_req;
  logic [2:0]  src_valid;
  logic [23:0] src_data;
  logic [14:0] src_flags;
  logic [2:0]  src_ack;
  logic [2:0]  src_grant;
  logic        snd_start;
  logic [7:0]  snd_data;
  logic [4:0]  snd_flags;
  logic        snd_done;
  logic        arb_busy;
  logic        timeout_err;

  uart_sender_arbiter #(
    .N_REQ(3), .DATA_W(8), .FLAG_W(5), .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk), .rst(rst),
    .src_req(src_req), .src_valid(src_valid),
    .src_data(src_data), .src_flags(src_flags),
    .src_ack(src_ack), .src_grant(src_grant),
    .snd_start(snd_start), .snd_data(snd_data), .snd_flags(snd_flags),
    .snd_done(snd_done), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int starts = 0;
  int multi  = 0;

  always @(posedge clk) begin
    if (snd_start) starts <= starts + 1;
    if ($countones(src_grant) > 1) multi <= multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    src_req   = '0;
    src_valid = '0;
    src_data  = '0;
    src_flags = '0;
    snd_done  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input logic [2:0] exp);
    int n = 0;
    while (src_grant == 3'b000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(src_grant), 32'(exp));
  endtask

  // Owner r sends one element; sender completes dly cycles after start.
  task automatic elem(input int r, input logic [7:0] d, input logic [4:0] f, input int dly);
    logic [2:0] one;
    one = 3'b001 << r;
    src_valid[r] = 1'b1;
    src_data[r*8 +: 8]  = d;
    src_flags[r*5 +: 5] = f;
    @(negedge clk);
    chk("ack", 32'(src_ack), 32'(one));
    chk("start_early", 32'(snd_start), 32'd0);
    src_valid[r] = 1'b0;
    @(negedge clk);
    chk("start", 32'(snd_start), 32'd1);
    chk("data", 32'(snd_data), 32'(d));
    chk("flags", 32'(snd_flags), 32'(f));
    chk("ack_pulse", 32'(src_ack), 32'd0);
    repeat (dly - 1) @(negedge clk);
    snd_done = 1'b1;
    @(negedge clk);
    snd_done = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=hang exp=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s;

    // ---- reset state and single transaction from requester 1 ----
    rst = 1'b1;
    src_req = '0; src_valid = '0; src_data = '0; src_flags = '0; snd_done = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(src_grant), 32'd0);
    chk("rst_ack", 32'(src_ack), 32'd0);
    chk("rst_start", 32'(snd_start), 32'd0);
    chk("rst_data", 32'(snd_data), 32'd0);
    chk("rst_flags", 32'(snd_flags), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    src_req = 3'b010;
    @(negedge clk);
    chk("t1_grant", 32'(src_grant), 32'h2);
    chk("t1_busy", 32'(arb_busy), 32'd1);
    elem(1, 8'h2A, 5'b00001, 10);
    chk("t1_hold", 32'(src_grant), 32'h2);
    src_req = 3'b000;
    @(negedge clk);
    chk("t1_release", 32'(src_grant), 32'd0);
    chk("t1_idle", 32'(arb_busy), 32'd0);

    // ---- all three contend: round-robin order 0,1,2 ----
    do_reset();
    s = starts;
    src_req = 3'b111;
    @(negedge clk);
    chk("t2_g0", 32'(src_grant), 32'h1);
    for (int r = 0; r < 3; r++) begin
      elem(r, 8'(8'h30 + r * 2), 5'(r + 1), 3);
      elem(r, 8'(8'h31 + r * 2), 5'(r + 8), 4);
      src_req[r] = 1'b0;
      @(negedge clk);
      chk("t2_release", 32'(src_grant), 32'd0);
      if (r < 2) wait_grant("t2_next", 3'b001 << (r + 1));
    end
    repeat (2) @(negedge clk);
    chk("t2_starts", 32'(starts - s), 32'd6);
    chk("t2_onehot", 32'(multi), 32'd0);

    // ---- no preemption, stray valid from non-owner ignored ----
    do_reset();
    src_req = 3'b001;
    @(negedge clk);
    chk("t3_g0", 32'(src_grant), 32'h1);
    src_req[2] = 1'b1;
    src_valid[2] = 1'b1;
    src_data[23:16] = 8'h77;
    elem(0, 8'h11, 5'b10000, 3);
    chk("t3_nopreempt", 32'(src_grant), 32'h1);
    elem(0, 8'h12, 5'b00010, 5);
    chk("t3_nopreempt2", 32'(src_grant), 32'h1);
    src_valid[2] = 1'b0;
    src_req[0] = 1'b0;
    @(negedge clk);
    chk("t3_release", 32'(src_grant), 32'd0);
    wait_grant("t3_g2", 3'b100);
    elem(2, 8'h55, 5'b01000, 2);
    src_req = 3'b000;
    @(negedge clk);

    // ---- owner drops request while the element is in flight ----
    do_reset();
    src_req = 3'b010;
    @(negedge clk);
    chk("t4_grant", 32'(src_grant), 32'h2);
    src_valid[1] = 1'b1;
    src_data[15:8] = 8'h9C;
    @(negedge clk);
    chk("t4_ack", 32'(src_ack), 32'h2);
    src_valid[1] = 1'b0;
    @(negedge clk);
    chk("t4_start", 32'(snd_start), 32'd1);
    src_req = 3'b000;
    repeat (3) @(negedge clk);
    chk("t4_inflight", 32'(src_grant), 32'h2);
    snd_done = 1'b1;
    @(negedge clk);
    snd_done = 1'b0;
    chk("t4_own", 32'(src_grant), 32'h2);
    s = starts;
    @(negedge clk);
    chk("t4_release", 32'(src_grant), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_nostart", 32'(starts - s), 32'd0);

    // ---- asynchronous reset in WAIT_DONE, then requester 0 first ----
    do_reset();
    src_req = 3'b010;
    @(negedge clk);
    src_valid[1] = 1'b1;
    src_data[15:8] = 8'hC3;
    src_flags[9:5] = 5'b10101;
    @(negedge clk);
    src_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_pre_data", 32'(snd_data), 32'hC3);
    #2 rst = 1'b1;
    #1;
    chk("t5_grant", 32'(src_grant), 32'd0);
    chk("t5_data", 32'(snd_data), 32'd0);
    chk("t5_flags", 32'(snd_flags), 32'd0);
    chk("t5_busy", 32'(arb_busy), 32'd0);
    chk("t5_ack", 32'(src_ack), 32'd0);
    chk("t5_start", 32'(snd_start), 32'd0);
    src_req = 3'b101;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_first", 32'(src_grant), 32'h1);
    src_req = 3'b000;
    @(negedge clk);

    // ---- sender never answers ----
    do_reset();
    src_req = 3'b001;
    @(negedge clk);
    src_valid[0] = 1'b1;
    src_data[7:0] = 8'h5A;
    @(negedge clk);
    src_valid[0] = 1'b0;
    @(negedge clk);
    chk("t6_start", 32'(snd_start), 32'd1);
`ifdef SENDER_TIMEOUT_EN
    repeat (19) @(negedge clk);
    chk("t6_terr_early", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("t6_terr", 32'(timeout_err), 32'd1);
    chk("t6_grant", 32'(src_grant), 32'h1);
    elem(0, 8'hA5, 5'b00100, 3);
    chk("t6_sticky", 32'(timeout_err), 32'd1);
    src_req = 3'b000;
    @(negedge clk);
    chk("t6_sticky_idle", 32'(timeout_err), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_terr_rst", 32'(timeout_err), 32'd0);
    do_reset();
`else
    repeat (25) @(negedge clk);
    chk("t6_terr_off", 32'(timeout_err), 32'd0);
    chk("t6_nostart", 32'(snd_start), 32'd0);
    chk("t6_waiting", 32'(arb_busy), 32'd1);
    snd_done = 1'b1;
    src_req = 3'b000;
    @(negedge clk);
    snd_done = 1'b0;
    @(negedge clk);
    chk("t6_release", 32'(src_grant), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_sender_arbiter.md
Name: uart_sender_arbiter

Overview:
- Sequences and shares the single UART sender between matrix-gen echo, matrix display and result printer.
- Replaces state-based steering with request/grant ownership, so several sources may contend without corrupting frames.
- Grants whole transactions (one matrix / summary), round-robin, and issues one element at a time to the sender.
- Waits for sender completion between elements and gives each source per-element acknowledges.

Parameters:
- N_REQ, 3: number of requesters (0 = gen, 1 = display, 2 = result).
- DATA_W, 8: element width, equal to matrix_element_t width.
- FLAG_W, 5: per-element format flags {sum_elem, sum_head, id, newline, last_col} (MSB..LSB).
- TIMEOUT_CYC, 65535: watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- src_req  in  N_REQ  per-requester transaction request; level, held for the whole transaction.
- src_valid  in  N_REQ  element valid; held with data/flags until acked.
- src_data  in  N_REQ*DATA_W  packed element data; requester i at [i*DATA_W +: DATA_W].
- src_flags  in  N_REQ*FLAG_W  packed format flags; requester i at [i*FLAG_W +: FLAG_W].
- src_ack  out  N_REQ  one-cycle pulse: element accepted.
- src_grant  out  N_REQ  one-hot current owner; all zero when idle.
- snd_start  out  1  one-cycle start pulse to the UART sender.
- snd_data  out  DATA_W  registered element to the sender.
- snd_flags  out  FLAG_W  registered flags to the sender.
- snd_done  in  1  sender finished the current element (pulse).
- arb_busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky watchdog error; optional feature only, else tied 0.

Behaviour:
- Reset (async, any state): state = IDLE; src_ack, src_grant, snd_start, snd_data, snd_flags, arb_busy, timeout_err all 0; rr_ptr = N_REQ-1, so requester 0 wins first.
- All outputs are registered.
- States: IDLE, OWN, ISSUE, WAIT_DONE.
- IDLE: when any src_req is high, pick the first set index scanning rr_ptr+1 upward, modulo N_REQ (wrap). Next cycle: src_grant one-hot, state = OWN, rr_ptr = winner.
- OWN:
  - If the owner's src_req is low: src_grant = 0, state = IDLE. A new arbitration can complete on the following cycle (one idle cycle minimum between owners).
  - Else if the owner's src_valid is high: latch its data/flags into snd_data/snd_flags, pulse src_ack[owner], state = ISSUE.
  - src_valid from non-owners is ignored and never acked.
- ISSUE: snd_start = 1 for exactly this cycle; state = WAIT_DONE.
- WAIT_DONE: on snd_done go to OWN. snd_data/snd_flags stay stable until the next latch.
  - A snd_done arriving in ISSUE or OWN is ignored.
- Latency: owner valid to src_ack is 1 cycle; to snd_start is 2 cycles. Element throughput is 3 cycles plus the sender time.
- Owner drops src_req during ISSUE/WAIT_DONE: the in-flight element completes, then OWN sees req low and releases.
- Owner holds src_valid high across the ack: treated as a new element on the next OWN visit. Requesters must drop or advance valid on ack.
- Requests arriving during ownership wait; there is no preemption mid-transaction.
- Reset mid-element abandons it; the sender sees no further start.

Optional Feature:
- Macro: SENDER_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE. When it reaches TIMEOUT_CYC without snd_done: timeout_err is set (sticky until rst), state = OWN, and the owner continues.
- Undefined: no counter, WAIT_DONE waits indefinitely, timeout_err is constant 0.

Test Plan:
- Reset release, req = 3'b010, one valid element 0x2A with flags 5'b00001, snd_done 10 cycles after start → grant = 010 next cycle; ack 1 cycle after valid; snd_start 2 cycles after valid with snd_data = 0x2A, snd_flags = 00001; release after req drops.
- req = 3'b111 held, each requester sends 2 elements then drops → grant order 001, 010, 100; 6 starts total, in requester order; never two grants at once.
- Owner 0 mid-transaction while req[2] rises → req 2 waits until req[0] drops; then grant = 100. Stray src_valid[2] during owner 0 gets no ack.
- Owner drops req in WAIT_DONE → element still completes on snd_done, then grant = 0; no extra snd_start.
- Assert rst during WAIT_DONE → all outputs 0 immediately. After release with req = 3'b101, requester 0 is granted first.
- With SENDER_TIMEOUT_EN and TIMEOUT_CYC = 20, snd_done withheld → timeout_err = 1 after 20 WAIT_DONE cycles and state returns to OWN. Next element still issues; timeout_err stays 1 until rst.
